// File: rtl/vga_timing_regs.sv
// VGA timing configuration registers: software edits a shadow set, which is
// validated and copied into the active set on a frame boundary.
module vga_timing_regs #(
  parameter int CONFIG_WIDTH  = 16,
  parameter int REZ_MAX_WIDTH = 11,
  parameter int PULSE_WIDTH   = 8,
  parameter int MARGIN_WIDTH  = 8,
  parameter logic [CONFIG_WIDTH-1:0] BASE_ADDR = 16'h0010
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     c_valid,
  input  logic [CONFIG_WIDTH-1:0]  c_addr,
  input  logic [CONFIG_WIDTH-1:0]  c_data,
  output logic                     c_ready,
  input  logic                     frame_end,
  output logic [REZ_MAX_WIDTH-1:0] h_count_max,
  output logic [REZ_MAX_WIDTH-1:0] v_count_max,
  output logic [PULSE_WIDTH-1:0]   h_sync_pulse,
  output logic [PULSE_WIDTH-1:0]   v_sync_pulse,
  output logic [MARGIN_WIDTH-1:0]  h_left_margin,
  output logic [MARGIN_WIDTH-1:0]  h_right_margin,
  output logic [MARGIN_WIDTH-1:0]  v_left_margin,
  output logic [MARGIN_WIDTH-1:0]  v_right_margin,
  output logic                     load_config,
  output logic                     cfg_err
);

  localparam int SUM_WIDTH = REZ_MAX_WIDTH + 2;

  typedef struct packed {
    logic [REZ_MAX_WIDTH-1:0] h_max;
    logic [REZ_MAX_WIDTH-1:0] v_max;
    logic [PULSE_WIDTH-1:0]   h_sync;
    logic [PULSE_WIDTH-1:0]   v_sync;
    logic [MARGIN_WIDTH-1:0]  h_left;
    logic [MARGIN_WIDTH-1:0]  h_right;
    logic [MARGIN_WIDTH-1:0]  v_left;
    logic [MARGIN_WIDTH-1:0]  v_right;
  } timing_t;

  typedef enum logic [1:0] {IDLE, PENDING, LOAD} state_t;

  function automatic timing_t preset_values(input logic [1:0] sel);
    timing_t t;
    case (sel)
      2'd1: begin
        t.h_max  = REZ_MAX_WIDTH'(1055); t.v_max   = REZ_MAX_WIDTH'(627);
        t.h_sync = PULSE_WIDTH'(128);    t.v_sync  = PULSE_WIDTH'(4);
        t.h_left = MARGIN_WIDTH'(88);    t.h_right = MARGIN_WIDTH'(40);
        t.v_left = MARGIN_WIDTH'(23);    t.v_right = MARGIN_WIDTH'(1);
      end
      2'd2: begin
        t.h_max  = REZ_MAX_WIDTH'(1343); t.v_max   = REZ_MAX_WIDTH'(805);
        t.h_sync = PULSE_WIDTH'(136);    t.v_sync  = PULSE_WIDTH'(6);
        t.h_left = MARGIN_WIDTH'(160);   t.h_right = MARGIN_WIDTH'(24);
        t.v_left = MARGIN_WIDTH'(29);    t.v_right = MARGIN_WIDTH'(3);
      end
      default: begin
        t.h_max  = REZ_MAX_WIDTH'(799);  t.v_max   = REZ_MAX_WIDTH'(524);
        t.h_sync = PULSE_WIDTH'(96);     t.v_sync  = PULSE_WIDTH'(2);
        t.h_left = MARGIN_WIDTH'(48);    t.h_right = MARGIN_WIDTH'(16);
        t.v_left = MARGIN_WIDTH'(33);    t.v_right = MARGIN_WIDTH'(10);
      end
    endcase
    return t;
  endfunction

  state_t  state, next_state;
  timing_t shadow, active;

  logic [CONFIG_WIDTH-1:0] offset;
  logic                    in_window;
  logic                    wr_en;
  logic                    sel_preset, sel_commit;
  logic                    preset_ok;
  logic                    arm_commit;
  logic [SUM_WIDTH-1:0]    h_sum, v_sum;
  logic                    shadow_valid;
  logic                    do_load, commit_err;

  assign offset     = c_addr - BASE_ADDR;
  assign in_window  = (c_addr >= BASE_ADDR) && (offset < CONFIG_WIDTH'(10));
  assign wr_en      = c_valid && c_ready;
  assign sel_preset = in_window && (offset[3:0] == 4'd0);
  assign sel_commit = in_window && (offset[3:0] == 4'd9);
  assign preset_ok  = (c_data < CONFIG_WIDTH'(3));
  assign arm_commit = wr_en && (sel_commit || (sel_preset && preset_ok));

  // Porch and sync widths must leave at least one active pixel/line.
  assign h_sum = SUM_WIDTH'(shadow.h_sync) + SUM_WIDTH'(shadow.h_left) + SUM_WIDTH'(shadow.h_right);
  assign v_sum = SUM_WIDTH'(shadow.v_sync) + SUM_WIDTH'(shadow.v_left) + SUM_WIDTH'(shadow.v_right);
  assign shadow_valid = (shadow.h_max != '0) && (shadow.v_max != '0) &&
                        (h_sum < SUM_WIDTH'(shadow.h_max)) &&
                        (v_sum < SUM_WIDTH'(shadow.v_max));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    do_load    = 1'b0;
    commit_err = 1'b0;
    case (state)
      IDLE:    if (arm_commit) next_state = PENDING;
      PENDING: begin
        if (frame_end) begin
          if (shadow_valid) begin
            next_state = LOAD;
            do_load    = 1'b1;
          end else begin
            next_state = IDLE;
            commit_err = 1'b1;
          end
        end
      end
      LOAD:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= preset_values(2'd0);
    end else if (wr_en) begin
      case (offset[3:0])
        4'd0: if (sel_preset && preset_ok) shadow <= preset_values(c_data[1:0]);
        4'd1: if (in_window) shadow.h_max   <= REZ_MAX_WIDTH'(c_data);
        4'd2: if (in_window) shadow.v_max   <= REZ_MAX_WIDTH'(c_data);
        4'd3: if (in_window) shadow.h_sync  <= PULSE_WIDTH'(c_data);
        4'd4: if (in_window) shadow.v_sync  <= PULSE_WIDTH'(c_data);
        4'd5: if (in_window) shadow.h_left  <= MARGIN_WIDTH'(c_data);
        4'd6: if (in_window) shadow.h_right <= MARGIN_WIDTH'(c_data);
        4'd7: if (in_window) shadow.v_left  <= MARGIN_WIDTH'(c_data);
        4'd8: if (in_window) shadow.v_right <= MARGIN_WIDTH'(c_data);
        default: ;
      endcase
    end
  end

  // load_config and c_ready follow the state being entered so they line up
  // with the edge that updates the active set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active      <= preset_values(2'd0);
      load_config <= 1'b1;
      c_ready     <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      if (do_load) active <= shadow;
      load_config <= (next_state == LOAD);
      c_ready     <= (next_state == IDLE);
      cfg_err     <= commit_err || (wr_en && sel_preset && !preset_ok);
    end
  end

  assign h_count_max    = active.h_max;
  assign v_count_max    = active.v_max;
  assign h_sync_pulse   = active.h_sync;
  assign v_sync_pulse   = active.v_sync;
  assign h_left_margin  = active.h_left;
  assign h_right_margin = active.h_right;
  assign v_left_margin  = active.v_left;
  assign v_right_margin = active.v_right;

endmodule

// File: tb/tb_vga_timing_regs.sv
// Directed testbench for vga_timing_regs: presets, field writes, validation
// failures, frame_end alignment and reset while a commit is pending.
module tb_vga_timing_regs;

  localparam logic [15:0] BASE = 16'h0010;

  logic        clk;
  logic        rst_n;
  logic        c_valid;
  logic [15:0] c_addr;
  logic [15:0] c_data;
  logic        c_ready;
  logic        frame_end;
  logic [10:0] h_count_max, v_count_max;
  logic [7:0]  h_sync_pulse, v_sync_pulse;
  logic [7:0]  h_left_margin, h_right_margin, v_left_margin, v_right_margin;
  logic        load_config;
  logic        cfg_err;

  int num_checks = 0;
  int num_errors = 0;

  vga_timing_regs dut (
    .clk(clk), .rst_n(rst_n),
    .c_valid(c_valid), .c_addr(c_addr), .c_data(c_data), .c_ready(c_ready),
    .frame_end(frame_end),
    .h_count_max(h_count_max), .v_count_max(v_count_max),
    .h_sync_pulse(h_sync_pulse), .v_sync_pulse(v_sync_pulse),
    .h_left_margin(h_left_margin), .h_right_margin(h_right_margin),
    .v_left_margin(v_left_margin), .v_right_margin(v_right_margin),
    .load_config(load_config), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Drives one cycle of inputs, then returns 1 time unit after the edge.
  task automatic applyStimulus(input logic v, input logic [15:0] off, input logic [15:0] d,
                               input logic fe);
    c_valid   = v;
    c_addr    = BASE + off;
    c_data    = d;
    frame_end = fe;
    @(posedge clk);
    #1;
    c_valid   = 1'b0;
    frame_end = 1'b0;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 16'd0, 16'd0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; c_valid = 1'b0; c_addr = '0; c_data = '0; frame_end = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_load", load_config, 1);
    checkOutput("rst_ready", c_ready, 0);
    checkOutput("rst_err", cfg_err, 0);
    checkOutput("rst_hmax", h_count_max, 799);
    checkOutput("rst_vmax", v_count_max, 524);
    rst_n = 1'b1;
    #2;
    checkOutput("rel_load_first", load_config, 1);
    idle();
    checkOutput("rel_load_second", load_config, 0);
    checkOutput("rel_ready", c_ready, 1);

    applyStimulus(1'b0, 16'd0, 16'd0, 1'b1);
    checkOutput("idle_fe_noload", load_config, 0);
    checkOutput("idle_fe_ready", c_ready, 1);

    // Preset 2, long wait before the frame boundary
    applyStimulus(1'b1, 16'd0, 16'd2, 1'b0);
    checkOutput("p2_ready", c_ready, 0);
    for (int i = 0; i < 10; i++) idle();
    checkOutput("p2_wait_ready", c_ready, 0);
    checkOutput("p2_wait_hmax", h_count_max, 799);
    checkOutput("p2_wait_load", load_config, 0);
    applyStimulus(1'b0, 16'd0, 16'd0, 1'b1);
    checkOutput("p2_load", load_config, 1);
    checkOutput("p2_hmax", h_count_max, 1343);
    checkOutput("p2_vmax", v_count_max, 805);
    checkOutput("p2_vsync", v_sync_pulse, 6);
    checkOutput("p2_hsync", h_sync_pulse, 136);
    checkOutput("p2_hleft", h_left_margin, 160);
    checkOutput("p2_hright", h_right_margin, 24);
    checkOutput("p2_vleft", v_left_margin, 29);
    checkOutput("p2_vright", v_right_margin, 3);
    checkOutput("p2_load_ready", c_ready, 0);
    idle();
    checkOutput("p2_load_end", load_config, 0);
    checkOutput("p2_ready_back", c_ready, 1);

    // Field edits then explicit commit
    applyStimulus(1'b1, 16'd3, 16'd200, 1'b0);
    applyStimulus(1'b1, 16'd2, 16'd627, 1'b0);
    checkOutput("edit_no_commit_ready", c_ready, 1);
    checkOutput("edit_active_hsync", h_sync_pulse, 136);
    applyStimulus(1'b1, 16'd9, 16'd0, 1'b0);
    checkOutput("commit_ready", c_ready, 0);
    applyStimulus(1'b0, 16'd0, 16'd0, 1'b1);
    checkOutput("edit_load", load_config, 1);
    checkOutput("edit_hsync", h_sync_pulse, 200);
    checkOutput("edit_vmax", v_count_max, 627);
    checkOutput("edit_hmax", h_count_max, 1343);
    checkOutput("edit_vsync", v_sync_pulse, 6);
    idle();

    // Bad preset and out-of-window address
    applyStimulus(1'b1, 16'd0, 16'd5, 1'b0);
    checkOutput("bad_preset_err", cfg_err, 1);
    checkOutput("bad_preset_ready", c_ready, 1);
    idle();
    checkOutput("bad_preset_err_end", cfg_err, 0);
    checkOutput("bad_preset_hsync", h_sync_pulse, 200);
    applyStimulus(1'b1, 16'd12, 16'd5, 1'b0);
    checkOutput("unmapped_err", cfg_err, 0);
    checkOutput("unmapped_ready", c_ready, 1);

    // Invalid shadow: 200+160+24 >= 100
    applyStimulus(1'b1, 16'd1, 16'd100, 1'b0);
    applyStimulus(1'b1, 16'd9, 16'd0, 1'b0);
    applyStimulus(1'b0, 16'd0, 16'd0, 1'b1);
    checkOutput("inv_err", cfg_err, 1);
    checkOutput("inv_noload", load_config, 0);
    checkOutput("inv_ready", c_ready, 1);
    checkOutput("inv_hmax", h_count_max, 1343);
    idle();
    checkOutput("inv_err_end", cfg_err, 0);

    // Preset 1 written alongside frame_end waits for the next boundary
    applyStimulus(1'b1, 16'd0, 16'd1, 1'b1);
    checkOutput("same_fe_noload", load_config, 0);
    checkOutput("same_fe_ready", c_ready, 0);
    checkOutput("same_fe_hmax", h_count_max, 1343);
    idle();
    applyStimulus(1'b0, 16'd0, 16'd0, 1'b1);
    checkOutput("p1_load", load_config, 1);
    checkOutput("p1_hmax", h_count_max, 1055);
    checkOutput("p1_vmax", v_count_max, 627);
    checkOutput("p1_hsync", h_sync_pulse, 128);
    checkOutput("p1_vsync", v_sync_pulse, 4);
    checkOutput("p1_vright", v_right_margin, 1);
    idle();

    // Boundary: sum equal to h_count_max is rejected, one more is accepted
    applyStimulus(1'b1, 16'd1, 16'd256, 1'b0);
    applyStimulus(1'b1, 16'd9, 16'd0, 1'b0);
    applyStimulus(1'b0, 16'd0, 16'd0, 1'b1);
    checkOutput("eq_err", cfg_err, 1);
    checkOutput("eq_hmax", h_count_max, 1055);
    applyStimulus(1'b1, 16'd1, 16'd257, 1'b0);
    applyStimulus(1'b1, 16'd9, 16'd0, 1'b0);
    applyStimulus(1'b0, 16'd0, 16'd0, 1'b1);
    checkOutput("gt_load", load_config, 1);
    checkOutput("gt_err", cfg_err, 0);
    checkOutput("gt_hmax", h_count_max, 257);
    idle();

    // Reset while pending discards the edit
    applyStimulus(1'b1, 16'd4, 16'd9, 1'b0);
    applyStimulus(1'b1, 16'd9, 16'd0, 1'b0);
    checkOutput("pend_ready", c_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("pend_rst_hmax", h_count_max, 799);
    checkOutput("pend_rst_vsync", v_sync_pulse, 2);
    checkOutput("pend_rst_load", load_config, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle();
    checkOutput("pend_rel_ready", c_ready, 1);
    applyStimulus(1'b0, 16'd0, 16'd0, 1'b1);
    checkOutput("pend_rel_noload", load_config, 0);
    applyStimulus(1'b1, 16'd9, 16'd0, 1'b0);
    applyStimulus(1'b0, 16'd0, 16'd0, 1'b1);
    checkOutput("post_rst_load", load_config, 1);
    checkOutput("post_rst_vsync", v_sync_pulse, 2);
    checkOutput("post_rst_hmax", h_count_max, 799);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_regs.md
VGA_TIMING_REGS -- requirements
Module: vga_timing_regs

Interface
REQ-001 Parameter CONFIG_WIDTH, default 16, width of c_addr and c_data.
REQ-002 Parameter REZ_MAX_WIDTH, default 11, width of h/v_count_max.
REQ-003 Parameter PULSE_WIDTH, default 8, width of h/v_sync_pulse.
REQ-004 Parameter MARGIN_WIDTH, default 8, width of all four margin outputs.
REQ-005 Parameter BASE_ADDR, default 16'h0010, first address of the register window.
REQ-006 clk  input  1  rising-edge clock; all state SHALL change on it, except for reset.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 c_valid  input  1  configuration write request.
REQ-009 c_addr  input  CONFIG_WIDTH  write address.
REQ-010 c_data  input  CONFIG_WIDTH  write data.
REQ-011 c_ready  output  1  write acceptance; a write SHALL occur only when c_valid=1 and c_ready=1 in the same cycle.
REQ-012 frame_end  input  1  one-cycle pulse from the pixel counters on the last pixel of a frame.
REQ-013 h_count_max, v_count_max  output  REZ_MAX_WIDTH  active total-minus-one counts.
REQ-014 h_sync_pulse, v_sync_pulse  output  PULSE_WIDTH  active sync widths.
REQ-015 h_left_margin, h_right_margin, v_left_margin, v_right_margin  output  MARGIN_WIDTH  active back-porch (left) and front-porch (right) widths.
REQ-016 load_config  output  1  one-cycle pulse when the active set changes.
REQ-017 cfg_err  output  1  one-cycle pulse when a write or commit is rejected.

Function
REQ-018 Address map, offsets from BASE_ADDR: 0 preset select; 1 h_count_max; 2 v_count_max; 3 h_sync; 4 v_sync; 5 h_left; 6 h_right; 7 v_left; 8 v_right; 9 commit. Other addresses are ignored and raise no error.
REQ-019 Block SHALL hold two register sets: shadow (written by software) and active (drives the outputs).
REQ-020 Writes to offsets 1-8 SHALL update only the shadow field, using the LSBs of c_data truncated to the field width.
REQ-021 Preset data values: 0 = 640x480, {799,524,96,2,48,16,33,10}; 1 = 800x600, {1055,627,128,4,88,40,23,1}; 2 = 1024x768, {1343,805,136,6,160,24,29,3}. Values are listed in offset order 1-8.
REQ-022 Preset write, data 0-2: all shadow fields SHALL load the listed values and a commit SHALL be armed.
REQ-023 Preset write, data >=3: shadow SHALL be unchanged and cfg_err SHALL pulse in the following cycle.
REQ-024 Commit write, any data: a commit SHALL be armed.
REQ-025 FSM states: IDLE, PENDING, LOAD.
REQ-026 IDLE: c_ready=1; an armed commit SHALL go to PENDING; frame_end SHALL be ignored.
REQ-027 PENDING: c_ready=0; on frame_end, validate the shadow set.
REQ-028 PENDING, shadow valid: active <= shadow and go to LOAD.
REQ-029 PENDING, shadow invalid: active SHALL be unchanged, cfg_err SHALL pulse, and the FSM SHALL return to IDLE.
REQ-030 LOAD: load_config=1 and c_ready=0 for exactly one cycle, then IDLE.
REQ-031 Shadow is invalid when h_count_max or v_count_max is 0, or when h_sync+h_left+h_right >= h_count_max (likewise for v), summed at REZ_MAX_WIDTH+2 bits without overflow.
REQ-032 A commit written in the same cycle as frame_end SHALL wait for the next frame_end.
REQ-033 Outputs SHALL be registered; active values SHALL change in the same edge that raises load_config.

Reset
REQ-034 On rst_n=0, shadow and active SHALL take preset 0, the FSM SHALL enter LOAD, and cfg_err=0.
REQ-035 load_config SHALL be 1 during reset and for the first cycle after release; c_ready SHALL then be 1 from the second cycle.
REQ-036 Reset asserted while in PENDING SHALL discard the pending commit and the shadow edits.

Verification
REQ-037 Release reset -> load_config=1 for one cycle, h_count_max=799, v_count_max=524, c_ready=1 from the second cycle.
REQ-038 Write preset 2, then frame_end after 10 cycles -> c_ready=0 during the wait, outputs stay 640x480 until frame_end, then h_count_max=1343 and v_sync_pulse=6 with a load_config pulse.
REQ-039 Write h_sync=200 and v_count_max=627, then commit, then frame_end -> active updated, other fields unchanged.
REQ-040 Write preset 5 -> cfg_err pulses, no state change, c_ready stays 1.
REQ-041 Write h_count_max=100, commit, frame_end -> cfg_err pulses, active unchanged, no load_config, FSM returns to IDLE.
REQ-042 Commit written in the same cycle as frame_end -> no load at that frame_end, load at the next one; rst_n asserted in PENDING -> preset 0 active.
